register_load_arbiter: RTL and testbench

//  Shares one parallel D-register (negedge-capturing, active-low clear, load enable) between NREQ requesters.

---
 rtl/register_load_arbiter_pkg.sv | 19 +
 rtl/register_load_arbiter_if.sv | 28 ++
 rtl/register_load_arbiter_rr_arbiter.sv | 35 +++
 rtl/register_load_arbiter.sv | 107 ++++++++++
 tb/tb_register_load_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/register_load_arbiter_pkg.sv
// Shared types for the register-load controller: FSM state encodings and sizing helpers.
// Future register controllers reuse the same state encoding.
package register_load_arbiter_pkg;

    localparam int DEF_SIZE = 8;
    localparam int DEF_NREQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ACK   = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/register_load_arbiter_if.sv
// Requester-side and register-side signals of the load arbiter.
// master = requester/testbench side, slave = arbiter side.
interface register_load_arbiter_if #(
    parameter int Size = 8,
    parameter int NREQ = 4
) ();
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]      req;
    logic [NREQ*Size-1:0] data;
    logic                 flush;
    logic [Size-1:0]      reg_d;
    logic                 reg_en;
    logic                 reg_clr_n;
    logic [NREQ-1:0]      ack;
    logic                 busy;
    logic [IDW-1:0]       owner;

    modport master (
        output req, data, flush,
        input  reg_d, reg_en, reg_clr_n, ack, busy, owner
    );

    modport slave (
        input  req, data, flush,
        output reg_d, reg_en, reg_clr_n, ack, busy, owner
    );
endinterface

// File: rtl/register_load_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr_i, wrapping.
// No state; the caller owns and advances the pointer.
module rr_arbiter
    import register_load_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  rr_ptr_i,
    output logic            gnt_valid_o,
    output logic [IDW-1:0]  gnt_idx_o
);

    int unsigned    idx;
    logic [IDW-1:0] cand;

    // Walk offsets high to low so the nearest requester to the pointer wins last.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        idx         = 0;
        cand        = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = int'(rr_ptr_i) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = IDW'(idx);
            if (req_i[cand]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/register_load_arbiter.sv
// Shares one external negedge D-register among NREQ requesters: round-robin load, ack, flush.
// One load per 3 cycles (grant, LOAD, ACK); flushes arriving while busy are held and run first.
module register_load_arbiter
    import register_load_arbiter_pkg::*;
#(
    parameter int Size = DEF_SIZE,
    parameter int NREQ = DEF_NREQ
) (
    input  logic                    clk,
    input  logic                    clr,
    register_load_arbiter_if.slave  bus
);

    localparam int IDW = idx_width(NREQ);

    state_e          state_q;
    logic [Size-1:0] reg_d_q;
    logic            reg_en_q;
    logic            reg_clr_n_q;
    logic [NREQ-1:0] ack_q;
    logic            busy_q;
    logic [IDW-1:0]  owner_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic            flush_pend_q;

    logic            gnt_vld;
    logic [IDW-1:0]  gnt_idx;
    logic [Size-1:0] data_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_data
        assign data_arr[i] = bus.data[i*Size +: Size];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i       (bus.req),
        .rr_ptr_i    (rr_ptr_q),
        .gnt_valid_o (gnt_vld),
        .gnt_idx_o   (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            reg_d_q      <= '0;
            reg_en_q     <= 1'b0;
            reg_clr_n_q  <= 1'b0;
            ack_q        <= '0;
            busy_q       <= 1'b0;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    reg_clr_n_q <= 1'b1;
                    if (bus.flush || flush_pend_q) begin
                        state_q      <= ST_CLEAR;
                        busy_q       <= 1'b1;
                        reg_clr_n_q  <= 1'b0;
                        flush_pend_q <= 1'b0;
                    end else if (gnt_vld) begin
                        state_q  <= ST_LOAD;
                        busy_q   <= 1'b1;
                        reg_d_q  <= data_arr[gnt_idx];
                        reg_en_q <= 1'b1;
                        owner_q  <= gnt_idx;
                        rr_ptr_q <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_q         <= ST_ACK;
                    reg_en_q        <= 1'b0;
                    ack_q           <= '0;
                    ack_q[owner_q]  <= 1'b1;
                    if (bus.flush) flush_pend_q <= 1'b1;
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    if (bus.flush) flush_pend_q <= 1'b1;
                end
                ST_CLEAR: begin
                    state_q     <= ST_IDLE;
                    reg_clr_n_q <= 1'b1;
                    busy_q      <= 1'b0;
                    if (bus.flush) flush_pend_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.reg_d     = reg_d_q;
    assign bus.reg_en    = reg_en_q;
    assign bus.reg_clr_n = reg_clr_n_q;
    assign bus.ack       = ack_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_register_load_arbiter.sv
// Bench for register_load_arbiter with a model of the shared negedge register.
// Expected loads are queued as stimulus is applied and retired on each ack pulse.
module tb_register_load_arbiter;

    localparam int SZ = 8;
    localparam int NR = 4;

    typedef struct {
        int          idx;
        logic [7:0]  dat;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic [SZ-1:0] reg_q;
    exp_t sb [$];
    int   n_chk = 0;
    int   n_err = 0;

    register_load_arbiter_if #(.Size(SZ), .NREQ(NR)) bus ();

    register_load_arbiter #(.Size(SZ), .NREQ(NR)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Shared register: captures on negedge when enabled, clears while clr_n is low.
    always @(negedge clk or negedge bus.reg_clr_n) begin
        if (!bus.reg_clr_n) reg_q <= '0;
        else if (bus.reg_en) reg_q <= bus.reg_d;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        bus.data[i*SZ +: SZ] = v;
    endtask

    task automatic expect_load(input int i, input logic [7:0] v);
        exp_t e;
        e.idx = i;
        e.dat = v;
        sb.push_back(e);
    endtask

    // Retire scoreboard entries on every ack pulse.
    always @(posedge clk) begin
        #1;
        if (bus.ack != '0) begin
            if (sb.size() == 0) begin
                chk("unexp_ack", 32'(bus.ack), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_onehot", 32'(bus.ack), 32'(1 << e.idx));
                chk("ack_owner", 32'(bus.owner), 32'(e.idx));
                chk("ack_reg_d", 32'(bus.reg_d), 32'(e.dat));
                chk("ack_reg_q", 32'(reg_q), 32'(e.dat));
            end
        end
    end

    // Run until all requesters are served; each drops req in its ack cycle.
    task automatic drain(input int budget, input bit chk_gap);
        int cyc;
        int last;
        cyc  = 0;
        last = -1;
        while ((bus.req != '0 || bus.busy) && cyc < budget) begin
            tick();
            cyc++;
            for (int i = 0; i < NR; i++) begin
                if (bus.ack[i]) begin
                    bus.req[i] = 1'b0;
                    if (chk_gap && last >= 0) chk("ack_gap", 32'(cyc - last), 32'd3);
                    last = cyc;
                end
            end
        end
        chk("drain_in_budget", 32'(cyc < budget), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req   = '0;
        bus.data  = '0;
        bus.flush = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_clr_n", 32'(bus.reg_clr_n), 32'd0);
        chk("rst_en", 32'(bus.reg_en), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd0);
        chk("rst_reg_d", 32'(bus.reg_d), 32'd0);
        clr = 1'b0;
        tick();
        chk("rel_clr_n", 32'(bus.reg_clr_n), 32'd1);
        chk("rel_busy", 32'(bus.busy), 32'd0);
        chk("rel_en", 32'(bus.reg_en), 32'd0);
        chk("rel_q", 32'(reg_q), 32'd0);

        // Fairness: all four requesting from rr_ptr=0
        for (int i = 0; i < NR; i++) begin
            set_data(i, 8'(8'h10 + i));
            expect_load(i, 8'(8'h10 + i));
        end
        bus.req = 4'b1111;
        drain(40, 1'b1);

        // Single load with explicit cycle timing
        set_data(2, 8'hA5);
        expect_load(2, 8'hA5);
        bus.req = 4'b0100;
        tick();
        chk("single_en", 32'(bus.reg_en), 32'd1);
        chk("single_busy", 32'(bus.busy), 32'd1);
        chk("single_owner", 32'(bus.owner), 32'd2);
        chk("single_noack", 32'(bus.ack), 32'd0);
        tick();
        chk("single_en_off", 32'(bus.reg_en), 32'd0);
        bus.req = '0;
        tick();
        chk("single_idle", 32'(bus.busy), 32'd0);
        chk("single_q", 32'(reg_q), 32'hA5);

        // Wrap: pointer now at 3
        set_data(3, 8'h33);
        set_data(0, 8'h11);
        expect_load(3, 8'h33);
        expect_load(0, 8'h11);
        bus.req = 4'b1001;
        drain(20, 1'b1);

        // Flush during LOAD of 8'h3C (pointer now 1)
        set_data(1, 8'h3C);
        expect_load(1, 8'h3C);
        bus.req = 4'b0010;
        tick();
        chk("fl_load_en", 32'(bus.reg_en), 32'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.req   = '0;
        tick();
        chk("fl_idle_clr_n", 32'(bus.reg_clr_n), 32'd1);
        tick();
        chk("fl_clear_clr_n", 32'(bus.reg_clr_n), 32'd0);
        chk("fl_clear_busy", 32'(bus.busy), 32'd1);
        chk("fl_clear_ack", 32'(bus.ack), 32'd0);
        chk("fl_clear_q", 32'(reg_q), 32'd0);
        tick();
        chk("fl_done_clr_n", 32'(bus.reg_clr_n), 32'd1);
        chk("fl_done_busy", 32'(bus.busy), 32'd0);
        chk("fl_hold_reg_d", 32'(bus.reg_d), 32'h3C);
        chk("fl_done_q", 32'(reg_q), 32'd0);

        // Simultaneous flush + req in IDLE: clear first, then load
        set_data(0, 8'h5A);
        expect_load(0, 8'h5A);
        bus.req   = 4'b0001;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("fr_clear_clr_n", 32'(bus.reg_clr_n), 32'd0);
        chk("fr_clear_en", 32'(bus.reg_en), 32'd0);
        drain(20, 1'b0);
        chk("fr_final_q", 32'(reg_q), 32'h5A);

        // clr asserted during LOAD drops the load
        set_data(2, 8'h77);
        bus.req = 4'b0100;
        tick();
        chk("cl_load_en", 32'(bus.reg_en), 32'd1);
        clr = 1'b1;
        tick();
        chk("cl_en", 32'(bus.reg_en), 32'd0);
        chk("cl_busy", 32'(bus.busy), 32'd0);
        chk("cl_clr_n", 32'(bus.reg_clr_n), 32'd0);
        chk("cl_ack", 32'(bus.ack), 32'd0);
        chk("cl_owner", 32'(bus.owner), 32'd0);
        chk("cl_q", 32'(reg_q), 32'd0);
        bus.req = '0;
        clr     = 1'b0;
        repeat (4) tick();
        chk("cl_after_clr_n", 32'(bus.reg_clr_n), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
